// File: rtl/keypad_pkg.sv
// Shared constants, key map and debounce state type for the matrix keypad entry block.
// Optional autorepeat is enabled by defining KEYPAD_AUTOREPEAT_EN.
package keypad_pkg;

    localparam int unsigned NUM_ROWS     = 4;
    localparam int unsigned NUM_COLS     = 4;
    localparam int unsigned REPEAT_FIRST = 64;
    localparam int unsigned REPEAT_NEXT  = 16;

    // Entry {row, col} holds the nibble printed on that key.
    localparam logic [15:0][3:0] KEY_MAP = {
        4'hD, 4'hF, 4'h0, 4'hE,
        4'hC, 4'h9, 4'h8, 4'h7,
        4'hB, 4'h6, 4'h5, 4'h4,
        4'hA, 4'h3, 4'h2, 4'h1
    };

    typedef enum logic [1:0] {
        IDLE,
        PRESS_PEND,
        HELD,
        RELEASE_PEND
    } deb_state_t;

    function automatic logic [3:0] key_lookup(input logic [1:0] row, input logic [1:0] col);
        return KEY_MAP[{row, col}];
    endfunction

endpackage

// File: rtl/keypad_hex_entry_if.sv
// CPU-side bundle of the keypad entry block: confirm/clear strobes in, entry state and published word out.
interface keypad_hex_entry_if;

    logic        confirm;
    logic        clear;
    logic [15:0] value;
    logic        value_valid;
    logic [15:0] entry_word;
    logic [2:0]  digit_count;
    logic [3:0]  key_code;
    logic        key_pulse;

    modport master (
        output confirm, clear,
        input  value, value_valid, entry_word, digit_count, key_code, key_pulse
    );

    modport slave (
        input  confirm, clear,
        output value, value_valid, entry_word, digit_count, key_code, key_pulse
    );

endinterface

// File: rtl/keypad_scanner.sv
// Column scan, row synchronizer, per-scan key resolution and debounce FSM for a 4x4 active-low keypad.
// Defining KEYPAD_AUTOREPEAT_EN adds repeat accepts while a key stays held.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_DIV       = 50000,
    parameter int unsigned DEBOUNCE_SCANS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_ROWS-1:0] row_in,
    output logic [NUM_COLS-1:0] col_out,
    output logic                key_pulse,
    output logic [3:0]          key_code
);

    localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned COL_W = $clog2(NUM_COLS);
    localparam int unsigned CNT_W = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(NUM_COLS - 1);
    localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_SCANS);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [NUM_ROWS-1:0] row_s1, row_s2;
    logic [DIV_W-1:0]    div_cnt;
    logic [COL_W-1:0]    col_idx;
    logic                dwell_end, scan_done;

    logic [1:0] hit_acc, hit_total;
    logic [3:0] key_acc, key_total, col_key;
    logic [2:0] col_hits, hit_sum;
    logic       res_valid;

    deb_state_t       state, state_nx;
    logic [3:0]       cand, cand_nx, code_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic             accept;

    // Two-flop synchronizer; idle rows read as released.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_s1 <= '1;
            row_s2 <= '1;
        end else begin
            row_s1 <= row_in;
            row_s2 <= row_s1;
        end
    end

    assign dwell_end = (div_cnt == DIV_LAST);
    assign scan_done = dwell_end && (col_idx == COL_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
            col_idx <= '0;
            col_out <= 4'b1110;
        end else if (dwell_end) begin
            div_cnt <= '0;
            col_idx <= col_idx + 1'b1;
            col_out <= ~(NUM_COLS'(1) << (col_idx + 1'b1));
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // Pressed rows in the current column; the code only matters when exactly one key is down.
    always_comb begin
        col_hits = '0;
        col_key  = '0;
        for (int r = NUM_ROWS - 1; r >= 0; r--) begin
            if (!row_s2[r]) begin
                col_hits = col_hits + 1'b1;
                col_key  = key_lookup(2'(r), col_idx);
            end
        end
    end

    assign hit_sum   = 3'(hit_acc) + col_hits;
    assign hit_total = (hit_sum >= 3'd2) ? 2'd2 : hit_sum[1:0];
    assign key_total = (col_hits != 3'd0) ? col_key : key_acc;
    assign res_valid = (hit_total == 2'd1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_acc <= '0;
            key_acc <= '0;
        end else if (scan_done) begin
            hit_acc <= '0;
            key_acc <= '0;
        end else if (dwell_end) begin
            hit_acc <= hit_total;
            key_acc <= key_total;
        end
    end

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int unsigned REP_W = $clog2(REPEAT_FIRST + 1);
    logic [REP_W-1:0] rep_cnt, rep_cnt_nx;
    logic             rep_first, rep_first_nx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rep_cnt   <= '0;
            rep_first <= 1'b1;
        end else begin
            rep_cnt   <= rep_cnt_nx;
            rep_first <= rep_first_nx;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cand      <= '0;
            cnt       <= '0;
            key_pulse <= 1'b0;
            key_code  <= '0;
        end else begin
            state     <= state_nx;
            cand      <= cand_nx;
            cnt       <= cnt_nx;
            key_pulse <= accept;
            key_code  <= code_nx;
        end
    end

    // Debounce decisions are taken only on the clock that completes a scan.
    always_comb begin
        state_nx = state;
        cand_nx  = cand;
        cnt_nx   = cnt;
        accept   = 1'b0;
        code_nx  = key_code;
`ifdef KEYPAD_AUTOREPEAT_EN
        rep_cnt_nx   = rep_cnt;
        rep_first_nx = rep_first;
`endif
        if (scan_done) begin
            case (state)
                IDLE: begin
                    if (res_valid) begin
                        cand_nx = key_total;
                        cnt_nx  = CNT_ONE;
                        if (CNT_ONE >= CNT_DONE) begin
                            state_nx = HELD;
                            accept   = 1'b1;
                        end else begin
                            state_nx = PRESS_PEND;
                        end
                    end
                end
                PRESS_PEND: begin
                    if (res_valid && (key_total == cand)) begin
                        cnt_nx = cnt + 1'b1;
                        if (cnt >= CNT_DONE - 1'b1) begin
                            state_nx = HELD;
                            accept   = 1'b1;
                        end
                    end else begin
                        state_nx = IDLE;
                    end
                end
                HELD: begin
                    if (!(res_valid && (key_total == cand))) begin
                        state_nx = RELEASE_PEND;
                        cnt_nx   = CNT_ONE;
`ifdef KEYPAD_AUTOREPEAT_EN
                        rep_cnt_nx   = '0;
                        rep_first_nx = 1'b1;
                    end else begin
                        rep_cnt_nx = rep_cnt + 1'b1;
                        if (rep_cnt_nx == (rep_first ? REP_W'(REPEAT_FIRST) : REP_W'(REPEAT_NEXT))) begin
                            accept       = 1'b1;
                            rep_cnt_nx   = '0;
                            rep_first_nx = 1'b0;
                        end
`endif
                    end
                end
                RELEASE_PEND: begin
                    if (!res_valid) begin
                        cnt_nx = cnt + 1'b1;
                        if (cnt >= CNT_DONE - 1'b1) begin
                            state_nx = IDLE;
                        end
                    end else if (key_total == cand) begin
                        state_nx = HELD;
                    end else begin
                        cnt_nx = CNT_ONE;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
        if (accept) begin
            code_nx = cand_nx;
        end
    end

endmodule

// File: rtl/keypad_hex_entry.sv
// Keypad hex entry: collects up to four debounced key nibbles into a word and publishes it on confirm.
// Autorepeat inside the scanner is compiled in with KEYPAD_AUTOREPEAT_EN.
module keypad_hex_entry
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_DIV       = 50000,
    parameter int unsigned DEBOUNCE_SCANS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_ROWS-1:0] row_in,
    output logic [NUM_COLS-1:0] col_out,
    keypad_hex_entry_if.slave   bus
);

    localparam logic [2:0] MAX_DIGITS = 3'd4;

    logic        key_pulse;
    logic [3:0]  key_code;
    logic [15:0] entry_word, value;
    logic [2:0]  digit_count;
    logic        value_valid;

    keypad_scanner #(
        .SCAN_DIV       (SCAN_DIV),
        .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
    ) u_scanner (
        .clk       (clk),
        .rst       (rst),
        .row_in    (row_in),
        .col_out   (col_out),
        .key_pulse (key_pulse),
        .key_code  (key_code)
    );

    // Confirm/clear act on the pre-accept word; a coincident key starts the next entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            entry_word  <= '0;
            digit_count <= '0;
            value       <= '0;
            value_valid <= 1'b0;
        end else begin
            value_valid <= 1'b0;
            if (bus.confirm && (digit_count != 3'd0)) begin
                value       <= entry_word;
                value_valid <= 1'b1;
            end
            if (bus.confirm || bus.clear) begin
                entry_word  <= key_pulse ? {12'h000, key_code} : 16'h0000;
                digit_count <= key_pulse ? 3'd1 : 3'd0;
            end else if (key_pulse) begin
                entry_word  <= {entry_word[11:0], key_code};
                digit_count <= (digit_count == MAX_DIGITS) ? MAX_DIGITS : digit_count + 1'b1;
            end
        end
    end

    assign bus.key_pulse   = key_pulse;
    assign bus.key_code    = key_code;
    assign bus.entry_word  = entry_word;
    assign bus.digit_count = digit_count;
    assign bus.value       = value;
    assign bus.value_valid = value_valid;

endmodule

// File: tb/tb_keypad_hex_entry.sv
// Bench for keypad_hex_entry: scan-aligned key patterns checked every cycle against a scan-level model.
module tb_keypad_hex_entry;

    localparam int unsigned SCAN_DIV = 4;
    localparam int          DEB      = 2;
    localparam int          SCAN_CYC = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  row_in;
    logic [3:0]  col_out;
    logic [15:0] pressed;

    keypad_hex_entry_if bus();

    keypad_hex_entry #(
        .SCAN_DIV       (SCAN_DIV),
        .DEBOUNCE_SCANS (DEB)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .row_in  (row_in),
        .col_out (col_out),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Physical matrix: a pressed key shorts its row to a column driven low.
    always_comb begin
        row_in = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && !col_out[c]) row_in[r] = 1'b0;
    end

    logic [3:0] kmap [16] = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
                              4'h7, 4'h8, 4'h9, 4'hC, 4'hE, 4'h0, 4'hF, 4'hD};

    int errors = 0;
    int checks = 0;
    int kp_seen, vv_seen;

    // Model state
    int          cyc;
    bit          m_kp, m_vv;
    logic [3:0]  m_kc;
    logic [15:0] m_word, m_val;
    int          m_cnt;
    bit          armed;
    int          run_key, run_len, last_acc, rel_len;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int scan_result(input logic [15:0] p);
        if ($countones(p) != 1) return -1;
        for (int i = 0; i < 16; i++) if (p[i]) return int'(kmap[i]);
        return -1;
    endfunction

    // Accept needs DEB identical key scans after a release of DEB non-key scans.
    task automatic debounce_scan(input int res);
        if (armed) begin
            if (res >= 0) begin
                if (res == run_key) run_len++;
                else begin run_key = res; run_len = 1; end
                if (run_len == DEB) begin
                    m_kp = 1'b1; m_kc = 4'(res);
                    armed = 1'b0; last_acc = res; rel_len = 0;
                end
            end else begin
                run_key = -1; run_len = 0;
            end
        end else begin
            if (res == last_acc) rel_len = 0;
            else if (res < 0)    rel_len++;
            else                 rel_len = 1;
            if (rel_len >= DEB) begin armed = 1'b1; run_key = -1; run_len = 0; end
        end
    endtask

    task automatic model_reset();
        cyc = 0; m_kp = 0; m_vv = 0; m_kc = '0; m_word = '0; m_val = '0; m_cnt = 0;
        armed = 1'b1; run_key = -1; run_len = 0; last_acc = -1; rel_len = 0;
    endtask

    task automatic model_edge(input bit cf, input bit cl);
        bit         acc;
        logic [3:0] ak;
        acc = m_kp; ak = m_kc;
        m_vv = 1'b0;
        if (cf && m_cnt > 0) begin m_val = m_word; m_vv = 1'b1; end
        if (cf || cl) begin
            m_word = acc ? {12'h000, ak} : 16'h0000;
            m_cnt  = acc ? 1 : 0;
        end else if (acc) begin
            m_word = {m_word[11:0], ak};
            if (m_cnt < 4) m_cnt++;
        end
        m_kp = 1'b0;
        cyc++;
        if (cyc % SCAN_CYC == 0) debounce_scan(scan_result(pressed));
    endtask

    task automatic check_outputs();
        logic [3:0] ecol;
        ecol = ~(4'b0001 << ((cyc / int'(SCAN_DIV)) % 4));
        check("col_out",     16'(col_out),         16'(ecol));
        check("key_pulse",   16'(bus.key_pulse),   16'(m_kp));
        check("key_code",    16'(bus.key_code),    16'(m_kc));
        check("entry_word",  bus.entry_word,       m_word);
        check("digit_count", 16'(bus.digit_count), 16'(m_cnt));
        check("value",       bus.value,            m_val);
        check("value_valid", 16'(bus.value_valid), 16'(m_vv));
        if (bus.key_pulse)   kp_seen++;
        if (bus.value_valid) vv_seen++;
    endtask

    task automatic step_cycle(input bit cf, input bit cl);
        bus.confirm = cf;
        bus.clear   = cl;
        @(posedge clk);
        model_edge(cf, cl);
        @(negedge clk);
        bus.confirm = 1'b0;
        bus.clear   = 1'b0;
        check_outputs();
    endtask

    task automatic scans(input logic [15:0] pat, input int n);
        pressed = pat;
        repeat (n * SCAN_CYC) step_cycle(1'b0, 1'b0);
    endtask

    task automatic rand_scans(input logic [15:0] pat, input int n);
        pressed = pat;
        repeat (n * SCAN_CYC) step_cycle($urandom_range(0, 39) == 0, $urandom_range(0, 59) == 0);
    endtask

    task automatic press(input int idx);
        scans(16'h0001 << idx, 3);
        scans(16'h0000, 3);
    endtask

    task automatic pulse(input bit cf, input bit cl);
        step_cycle(cf, cl);
        repeat (SCAN_CYC - 1) step_cycle(1'b0, 1'b0);
    endtask

    // Asynchronous reset asserted away from any clock edge.
    task automatic do_reset();
        rst = 1'b1;
        pressed = '0;
        bus.confirm = 1'b0;
        bus.clear   = 1'b0;
        #1;
        check("rst col_out",     16'(col_out),         16'h000E);
        check("rst value",       bus.value,            16'h0000);
        check("rst value_valid", 16'(bus.value_valid), 16'h0000);
        check("rst entry_word",  bus.entry_word,       16'h0000);
        check("rst digit_count", 16'(bus.digit_count), 16'h0000);
        check("rst key_code",    16'(bus.key_code),    16'h0000);
        check("rst key_pulse",   16'(bus.key_pulse),   16'h0000);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [15:0] p, prev_p;
        int          kind, len, a, b;

        rst = 1'b1;
        pressed = '0;
        bus.confirm = 1'b0;
        bus.clear   = 1'b0;
        @(negedge clk);
        do_reset();

        // Single press of 6 held, then released
        kp_seen = 0;
        scans(16'h0001 << 6, 5);
        scans(16'h0000, 3);
        check("t2 pulses",      16'(kp_seen),         16'd1);
        check("t2 key_code",    16'(bus.key_code),    16'h0006);
        check("t2 entry_word",  bus.entry_word,       16'h0006);
        check("t2 digit_count", 16'(bus.digit_count), 16'd1);
        pulse(1'b0, 1'b1);
        check("clear entry_word", bus.entry_word, 16'h0000);

        // 1 2 3 A then confirm
        vv_seen = 0;
        press(0); press(1); press(2); press(3);
        check("t3 entry_word", bus.entry_word, 16'h123A);
        pulse(1'b1, 1'b0);
        check("t3 value",       bus.value,            16'h123A);
        check("t3 valid count", 16'(vv_seen),         16'd1);
        check("t3 entry_word",  bus.entry_word,       16'h0000);
        check("t3 digit_count", 16'(bus.digit_count), 16'd0);

        // Five digits: oldest shifts out
        press(0); press(1); press(2); press(4); press(5);
        check("t4 digit_count", 16'(bus.digit_count), 16'd4);
        check("t4 entry_word",  bus.entry_word,       16'h2345);
        pulse(1'b1, 1'b0);
        check("t4 value", bus.value, 16'h2345);

        // Bouncing key and a two-key press never accept
        kp_seen = 0;
        for (int i = 0; i < 3; i++) begin
            scans(16'h0001, 1);
            scans(16'h0000, 1);
        end
        scans(16'h0003, 4);
        scans(16'h0000, 2);
        check("t5 pulses", 16'(kp_seen), 16'd0);

        // Confirm wins over clear; empty confirm ignored
        press(8);
        vv_seen = 0;
        pulse(1'b1, 1'b1);
        check("t6 value",       bus.value,      16'h0007);
        check("t6 valid count", 16'(vv_seen),   16'd1);
        check("t6 entry_word",  bus.entry_word, 16'h0000);
        pulse(1'b1, 1'b0);
        check("t6 empty valid", 16'(vv_seen),   16'd1);
        check("t6 value kept",  bus.value,      16'h0007);

        // Accept coinciding with confirm: old word published, key starts new entry
        press(5);
        scans(16'h0001 << 11, 2);
        step_cycle(1'b1, 1'b0);
        repeat (SCAN_CYC - 1) step_cycle(1'b0, 1'b0);
        scans(16'h0000, 3);
        check("sim value",       bus.value,            16'h0005);
        check("sim entry_word",  bus.entry_word,       16'h000C);
        check("sim digit_count", 16'(bus.digit_count), 16'd1);

        // Randomized key patterns with sporadic confirm/clear
        prev_p = '0;
        for (int s = 0; s < 60; s++) begin
            kind = $urandom_range(0, 9);
            len  = $urandom_range(1, 5);
            if (kind < 3) begin
                p = '0;
            end else if (kind < 4) begin
                a = $urandom_range(0, 15);
                b = (a + $urandom_range(1, 15)) % 16;
                p = (16'h0001 << a) | (16'h0001 << b);
            end else begin
                p = 16'h0001 << $urandom_range(0, 15);
            end
            if ($countones(p) == 1 && $countones(prev_p) == 1 && p != prev_p) rand_scans(16'h0000, 1);
            rand_scans(p, len);
            prev_p = p;
        end

        // Reset in the middle of a scan with a partial entry
        scans(16'h0000, 3);
        press(14);
        pressed = 16'h0001 << 6;
        repeat (5) step_cycle(1'b0, 1'b0);
        do_reset();
        press(6);
        check("post-rst entry_word",  bus.entry_word,       16'h0006);
        check("post-rst digit_count", 16'(bus.digit_count), 16'd1);
        check("post-rst value",       bus.value,            16'h0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
